// File: rtl/shift_rows_pipe_pkg.sv
// Shared Rijndael definitions for the ShiftRows stage: legal block widths,
// per-width row offsets and the source-column helper used by the permutation.
package shift_rows_pipe_pkg;

    // Handshake occupancy states; the encoding equals the number of held blocks.
    typedef enum logic [1:0] {
        stEmpty = 2'd0,
        stOne   = 2'd1,
        stFull  = 2'd2
    } pipeStateT;

    // Rijndael allows 4, 6 or 8 state columns.
    function automatic bit nbLegal(input int nb);
        return (nb == 4) || (nb == 6) || (nb == 8);
    endfunction

    // Row offsets: {0,1,2,3} for Nb = 4 or 6, {0,1,3,4} for Nb = 8.
    function automatic int rowOffset(input int r, input int nb);
        int off;
        off = r;
        if (nb == 8) begin
            case (r)
                0:       off = 0;
                1:       off = 1;
                2:       off = 3;
                default: off = 4;
            endcase
        end
        return off;
    endfunction

    // Source column that feeds output (r, c) in the chosen direction.
    function automatic int shift_index(input int r, input int c, input int nb, input bit inverse);
        int off;
        off = rowOffset(r, nb);
        if (inverse) begin
            return (c - off + nb) % nb;
        end
        return (c + off) % nb;
    endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation. Byte k sits at
// data[W-1-8k -: 8] (byte 0 is the MSB byte) and belongs to row k%4, column k/4.
module shift_rows_perm
    import shift_rows_pipe_pkg::*;
#(
    parameter int NB = 4,
    localparam int W = 32 * NB
) (
    input  logic [W-1:0] data,
    input  logic         inverse,
    output logic [W-1:0] result
);

    // Refuse to build for a block width Rijndael does not define.
    if (!nbLegal(NB)) begin : g_badNb
        $error("shift_rows_perm: NB must be 4, 6 or 8");
    end

    logic [W-1:0] fwdData;
    logic [W-1:0] invData;

    // Both directions are fixed wiring; the flag just picks one of them.
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int dst    = 4 * c + r;
            localparam int fwdSrc = 4 * shift_index(r, c, NB, 1'b0) + r;
            localparam int invSrc = 4 * shift_index(r, c, NB, 1'b1) + r;
            assign fwdData[W-1-8*dst -: 8] = data[W-1-8*fwdSrc -: 8];
            assign invData[W-1-8*dst -: 8] = data[W-1-8*invSrc -: 8];
        end
    end

    assign result = inverse ? invData : fwdData;

endmodule

// File: rtl/shift_rows_pipe.sv
// Registered ShiftRows / InvShiftRows stage with a 2-entry skid buffer.
// Handshake: a block moves on an interface in every cycle where valid and
// ready are both high at the rising edge; valid never depends on ready, and
// in_ready depends only on registered occupancy, so out_ready has no
// combinational path to in_ready. Data is permuted before it is stored, so
// both the main and skid registers hold finished output blocks.
module shift_rows_pipe
    import shift_rows_pipe_pkg::*;
#(
    parameter int NB = 4,
    localparam int W = 32 * NB
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_inverse,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_inverse
);

    pipeStateT    state;
    pipeStateT    stateNext;
    logic [W-1:0] permData;
    logic [W-1:0] mainData;
    logic         mainInv;
    logic [W-1:0] skidData;
    logic         skidInv;
    logic         inXfer;
    logic         outXfer;
    logic         loadMain;
    logic         loadSkid;
    logic         mainFromSkid;

    shift_rows_perm #(.NB(NB)) uPerm (
        .data    (in_data),
        .inverse (in_inverse),
        .result  (permData)
    );

    assign in_ready    = (state != stFull);
    assign out_valid   = (state != stEmpty);
    assign out_data    = mainData;
    assign out_inverse = mainInv;
    assign inXfer      = in_valid & in_ready;
    assign outXfer     = out_valid & out_ready;

    // Next occupancy and which register captures what on this edge.
    always_comb begin
        stateNext    = state;
        loadMain     = 1'b0;
        loadSkid     = 1'b0;
        mainFromSkid = 1'b0;
        case (state)
            stEmpty: begin
                if (inXfer) begin
                    loadMain  = 1'b1;
                    stateNext = stOne;
                end
            end
            stOne: begin
                if (inXfer && outXfer) begin
                    loadMain = 1'b1;
                end else if (inXfer) begin
                    loadSkid  = 1'b1;
                    stateNext = stFull;
                end else if (outXfer) begin
                    stateNext = stEmpty;
                end
            end
            stFull: begin
                if (outXfer) begin
                    mainFromSkid = 1'b1;
                    stateNext    = stOne;
                end
            end
            default: stateNext = stEmpty;
        endcase
    end

    // Occupancy register; reset wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= stEmpty;
        end else begin
            state <= stateNext;
        end
    end

    // Block storage; registers change only on reset or an actual transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            mainData <= '0;
            mainInv  <= 1'b0;
            skidData <= '0;
            skidInv  <= 1'b0;
        end else begin
            if (loadMain) begin
                mainData <= permData;
                mainInv  <= in_inverse;
            end else if (mainFromSkid) begin
                mainData <= skidData;
                mainInv  <= skidInv;
            end
            if (loadSkid) begin
                skidData <= permData;
                skidInv  <= in_inverse;
            end
        end
    end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Bench for shift_rows_pipe (NB = 4) plus standalone shift_rows_perm
// instances for NB = 4, 6 and 8 checked against a byte-level reference.
module tb_shift_rows_pipe;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_inverse;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_inverse;

    logic [127:0] s4In, s4Mid, s4Out;
    logic [191:0] s6In, s6Mid, s6Out;
    logic [255:0] s8In, s8Mid, s8Out;

    int           nAsserts = 0;
    int           nFails = 0;
    logic [128:0] exp_q[$];
    bit           lastIn;

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL global_timeout observed=still running required=finished");
        $fatal(1, "timeout");
    end

    shift_rows_pipe #(.NB(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_inverse  (in_inverse),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_inverse (out_inverse)
    );

    shift_rows_perm #(.NB(4)) p4f (.data(s4In),  .inverse(1'b0), .result(s4Mid));
    shift_rows_perm #(.NB(4)) p4i (.data(s4Mid), .inverse(1'b1), .result(s4Out));
    shift_rows_perm #(.NB(6)) p6f (.data(s6In),  .inverse(1'b0), .result(s6Mid));
    shift_rows_perm #(.NB(6)) p6i (.data(s6Mid), .inverse(1'b1), .result(s6Out));
    shift_rows_perm #(.NB(8)) p8f (.data(s8In),  .inverse(1'b0), .result(s8Mid));
    shift_rows_perm #(.NB(8)) p8i (.data(s8Mid), .inverse(1'b1), .result(s8Out));

    // Reference: rebuild the state byte by byte from the row/column rules.
    function automatic logic [255:0] refShift(input logic [255:0] d, input int nb, input bit inv);
        logic [255:0] res;
        int offs[4];
        int w, r, c, src;
        res = '0;
        w = 32 * nb;
        if (nb == 8) offs = '{0, 1, 3, 4};
        else         offs = '{0, 1, 2, 3};
        for (int k = 0; k < 4 * nb; k++) begin
            r = k % 4;
            c = k / 4;
            src = inv ? (c - offs[r] + nb) % nb : (c + offs[r]) % nb;
            res[w-1-8*k -: 8] = d[w-1-8*(4*src+r) -: 8];
        end
        return res;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
        return v;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        nAsserts++;
        assert (obs === expv) else begin
            nFails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Driver + scoreboard: account for this cycle's transfers, then advance
    // to 1 time unit after the next rising edge.
    task automatic step();
        logic [255:0] m;
        logic [128:0] e;
        bit inX, outX;
        inX  = (in_valid === 1'b1) && (in_ready === 1'b1);
        outX = (out_valid === 1'b1) && (out_ready === 1'b1);
        lastIn = 1'b0;
        if (reset) begin
            exp_q.delete();
        end else begin
            if (outX) begin
                nAsserts++;
                assert (exp_q.size() != 0) else begin
                    nFails++;
                    $error("FAIL spurious_out observed=beat %h required=no beat", out_data);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_beat", 256'({out_inverse, out_data}), 256'(e));
                end
            end
            if (inX) begin
                m = refShift(256'(in_data), 4, in_inverse);
                exp_q.push_back({in_inverse, m[127:0]});
                lastIn = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6 && exp_q.size() != 0; i++) step();
        check(tag, 256'(exp_q.size()), 256'(0));
    endtask

    initial begin
        logic [127:0] held;
        bit cAccepted;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_inverse = 1'b0; out_ready = 1'b0;
        s4In = '0; s6In = '0; s8In = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_in_ready", 256'(in_ready), 256'(1));
        check("rst_out_data", 256'(out_data), 256'(0));
        check("rst_out_inverse", 256'(out_inverse), 256'(0));
        reset = 1'b0;
        step();

        // NB = 8 directed vector: bytes 0x00..0x1f ascending
        for (int k = 0; k < 32; k++) s8In[255-8*k -: 8] = 8'(k);
        #1;
        check("nb8_byte2", 256'(s8Mid[255-16 -: 8]), 256'(8'h0e));
        check("nb8_byte3", 256'(s8Mid[255-24 -: 8]), 256'(8'h13));
        check("nb8_fwd_vec", s8Mid, refShift(s8In, 8, 1'b0));
        check("nb8_inv_vec", s8Out, s8In);
        s4In = 128'hd42711aee0bf98f1b8b45de51e415230;
        #1;
        check("perm_fips_fwd", 256'(s4Mid), 256'(128'hd4bf5d30e0b452aeb84111f11e2798e5));
        check("perm_fips_inv", 256'(s4Out), 256'(s4In));

        // Random identity and reference checks for all block widths
        for (int i = 0; i < 1000; i++) begin
            s8In = rand256();
            s6In = s8In[191:0] ^ rand256() >> 64;
            s4In = s8In[255:128];
            #1;
            check("nb4_fwd", 256'(s4Mid), refShift(256'(s4In), 4, 1'b0));
            check("nb4_ident", 256'(s4Out), 256'(s4In));
            check("nb6_fwd", 256'(s6Mid), refShift(256'(s6In), 6, 1'b0));
            check("nb6_ident", 256'(s6Out), 256'(s6In));
            check("nb8_fwd", s8Mid, refShift(s8In, 8, 1'b0));
            check("nb8_ident", s8Out, s8In);
        end

        // Test 1: ascending bytes forward, one-cycle latency
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 128'h000102030405060708090a0b0c0d0e0f; in_inverse = 1'b0;
        step();
        in_valid = 1'b0;
        check("t1_out_valid", 256'(out_valid), 256'(1));
        check("t1_out_data", 256'(out_data), 256'(128'h00050a0f04090e03080d02070c01060b));
        check("t1_out_inverse", 256'(out_inverse), 256'(0));
        step();

        // Test 2: FIPS-197 round-1 vector and its inverse back-to-back
        in_valid = 1'b1; in_data = 128'hd42711aee0bf98f1b8b45de51e415230; in_inverse = 1'b0;
        step();
        in_data = 128'hd4bf5d30e0b452aeb84111f11e2798e5; in_inverse = 1'b1;
        check("t2_fwd", 256'(out_data), 256'(128'hd4bf5d30e0b452aeb84111f11e2798e5));
        step();
        in_valid = 1'b0;
        check("t2_inv", 256'(out_data), 256'(128'hd42711aee0bf98f1b8b45de51e415230));
        check("t2_inv_flag", 256'(out_inverse), 256'(1));
        drain("t2_drained");

        // Test 4: backpressure with A, B, C
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = rand256(); in_inverse = 1'b0;
        step();
        check("t4_ready_after_a", 256'(in_ready), 256'(1));
        in_data = rand256(); in_inverse = 1'b1;
        step();
        check("t4_ready_after_b", 256'(in_ready), 256'(0));
        in_data = rand256(); in_inverse = 1'b0;
        held = out_data;
        check("t4_head_is_a", 256'(out_data), 256'(exp_q[0][127:0]));
        step();
        step();
        check("t4_stable", 256'(out_data), 256'(held));
        check("t4_still_full", 256'(in_ready), 256'(0));
        check("t4_queue_depth", 256'(exp_q.size()), 256'(2));
        out_ready = 1'b1;
        cAccepted = 1'b0;
        for (int i = 0; i < 8 && (exp_q.size() != 0 || in_valid); i++) begin
            step();
            if (lastIn) begin
                cAccepted = 1'b1;
                in_valid = 1'b0;
            end
        end
        check("t4_c_accepted", 256'(cAccepted), 256'(1));
        check("t4_drained", 256'(exp_q.size()), 256'(0));

        // Test 5: alternating direction at full rate
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = rand256(); in_inverse = i[0];
            step();
            check("t5_in_ready", 256'(in_ready), 256'(1));
        end
        drain("t5_drained");

        // Test 6: reset while FULL with in_valid high
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = rand256(); step();
        in_data = rand256(); step();
        check("t6_full", 256'(in_ready), 256'(0));
        in_data = rand256(); reset = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0;
        check("t6_out_valid", 256'(out_valid), 256'(0));
        check("t6_in_ready", 256'(in_ready), 256'(1));
        check("t6_out_data", 256'(out_data), 256'(0));
        check("t6_out_inverse", 256'(out_inverse), 256'(0));
        out_ready = 1'b1;
        repeat (4) step();
        check("t6_no_emit", 256'(out_valid), 256'(0));
        // in_valid during reset from EMPTY must not be accepted
        in_valid = 1'b1; in_data = rand256(); reset = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0;
        check("t6_rst_in_ignored", 256'(out_valid), 256'(0));

        // Random traffic against the scoreboard
        for (int i = 0; i < 600; i++) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_data    = 128'(rand256());
            in_inverse = 1'($urandom_range(0, 1));
            out_ready  = ($urandom_range(0, 3) != 0);
            step();
        end
        drain("rand_drained");

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
Parametrised, registered ShiftRows / InvShiftRows stage for the Rijndael datapath. It supports block widths Nb = 4, 6 or 8 columns, with the direction selected per transaction. The stage sits between the SubBytes and MixColumns stages of the round pipeline. It uses a valid/ready handshake and a 2-entry skid buffer, so that in_ready is a registered signal and no combinational path exists from out_ready to in_ready.

Parameters:
NB, 4, state columns; legal values 4, 6, 8; any other value fails elaboration (generate-time $error-equivalent via an illegal localparam).
W, 32*NB, derived state width in bits; not overridable.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  input block present
in_ready  out  1  stage can accept a block this cycle
in_data  in  W  input state
in_inverse  in  1  0 = ShiftRows, 1 = InvShiftRows; sampled with in_data
out_valid  out  1  output block present
out_ready  in  1  downstream accepts this cycle
out_data  out  W  shifted state
out_inverse  out  1  in_inverse carried alongside out_data for the next stage

Behaviour:
- Byte map:
  - State byte k (k = 0..4*NB-1) occupies in_data[W-1-8k -: 8], so byte 0 is the MSB byte.
  - Byte k is row r = k mod 4, column c = k div 4.
- Row offsets C[r]:
  - NB = 4 or 6: C = {0, 1, 2, 3}.
  - NB = 8: C = {0, 1, 3, 4}.
- Forward: out(r, c) = in(r, (c + C[r]) mod NB).
- Inverse: out(r, c) = in(r, (c - C[r] + NB) mod NB).
- Permutation is pure wiring; only the handshake is sequential.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- Storage:
  - Main register M holds the permuted data plus its inverse flag.
  - Skid register S holds the same.
  - Occupancy count is 0, 1 or 2.
- State machine:
  - EMPTY (0): in_ready = 1, out_valid = 0. An input transfer loads M and moves to ONE.
  - ONE (1): in_ready = 1, out_valid = 1.
    - Input without output: load S, go to FULL.
    - Output without input: go to EMPTY.
    - Input and output together: load M, stay ONE.
    - Neither: hold.
  - FULL (2): in_ready = 0, out_valid = 1.
    - Output transfer: M <= S, go to ONE.
    - in_valid is ignored while in FULL.
- Ordering and latency:
  - Order is strictly FIFO; no reordering and no loss.
  - Minimum latency is 1 cycle: in_data accepted at edge N appears on out_data after edge N.
  - Throughput is 1 block per cycle while out_ready = 1.
- in_ready is a pure function of the registered state (count < 2).
- Holding rules:
  - out_data and out_inverse stay stable while out_valid = 1 and out_ready = 0.
  - in_inverse may differ on every transfer, and each block carries its own flag.
- Reset:
  - Reset has priority over all handshakes in the same cycle.
  - Next state is EMPTY: out_valid = 0, in_ready = 1, out_data = 0, out_inverse = 0, S cleared.
  - Reset mid-stream discards both held blocks silently.
  - in_valid during the reset cycle is not accepted.
- No X propagation: data registers load only on transfer.

Decomposition:
- Shared package/include (rijndael_defs): NB legal values, row-offset constants per NB, and a function shift_index(r, c, nb, inverse) returning the source column.
- Sub-module shift_rows_perm: parametrised (NB) combinational permutation, taking data plus inverse and returning data.
  - Instantiated once at the input, so both M and S store already-permuted data.
  - The FIPS-197 byte-order checks are reused on shift_rows_perm standalone.

Test Plan:
1. NB=4, forward, in_data = 0x000102030405060708090a0b0c0d0e0f, out_ready=1 -> one cycle later out_data = 0x00050a0f04090e03080d02070c01060b, out_inverse=0.
2. NB=4, FIPS-197 round 1 vector d42711aee0bf98f1b8b45de51e415230 forward -> d4bf5d30e0b452aeb84111f11e2798e5; feeding that result back with inverse=1 -> original value.
3. NB=8, forward, bytes 0x00..0x1f ascending -> row 2 shifted by 3 and row 3 by 4; byte 2 of output = 0x0e, byte 3 = 0x13. Forward then inverse over 1000 random blocks is the identity for NB=4, 6 and 8.
4. Backpressure, NB=4: push blocks A, B, C back-to-back with out_ready=0 -> in_ready drops after B; C is held off. Raise out_ready -> A, B, C emerge in order, and out_data is stable while stalled.
5. Alternating in_inverse per beat (0, 1, 0, 1) at full rate -> each output matches its own direction and out_inverse follows 0, 1, 0, 1.
6. Assert reset while FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, out_data=0, and no held block is ever emitted.
